// File: rtl/sd_dma_tx_pkg.sv
// Shared constants, state types and the CRC16 helper for the SD SPI write-side DMA.
// The CRC16 helper is only used by builds with SD_DMA_TX_CRC16_EN defined.
package sd_dma_tx_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_ADDR_W = 24;
  localparam logic [1:0] BANK_ROM = 2'b00;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    DONE
  } fetch_state_e;

  typedef enum logic [1:0] {
    TAIL_NONE,
    TAIL_HI,
    TAIL_LO
  } tail_state_e;

  // MSB-first CRC16-CCITT over one byte
  function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_tx_word_fifo.sv
// Small synchronous word FIFO between the bus fetch side and the byte unpacker.
module sd_tx_word_fifo
  import sd_dma_tx_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [BUS_DATA_W-1:0]      push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [BUS_DATA_W-1:0]      head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [FIFO_DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = DEPTH[FIFO_DEPTH_LOG2:0];

  logic [BUS_DATA_W-1:0]      mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic                       do_push, do_pop;

  // A pop frees the head slot in the same cycle, so a full FIFO may still push
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != DEPTH_CNT) || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/sd_dma_tx.sv
// Memory-to-card DMA: fetches bus words into a FIFO and streams them MSB byte first.
// Optional SD_DMA_TX_CRC16_EN adds a running CRC16 and appends it after the data bytes.
module sd_dma_tx
  import sd_dma_tx_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int LENGTH_W        = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [BUS_ADDR_W-1:0] i_base,
  input  logic [LENGTH_W-1:0]   i_length,
  output logic                  o_busy,
  output logic                  o_fifo_empty,
  output logic                  o_fifo_full,
  output logic                  o_request,
  output logic                  o_write,
  input  logic                  i_busy,
  input  logic                  i_ack,
  output logic [BUS_ADDR_W-1:0] o_address,
  input  logic [BUS_DATA_W-1:0] i_data,
  output logic [7:0]            o_byte,
  output logic                  o_byte_valid,
  input  logic                  i_byte_ready,
  output logic [15:0]           o_crc16
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = DEPTH[FIFO_DEPTH_LOG2:0];

  fetch_state_e              state_q, state_d;
  logic [BUS_ADDR_W-1:0]     addr_q;
  logic [LENGTH_W-1:0]       left_q;
  logic                      fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [BUS_DATA_W-1:0]     fifo_head;
  logic [FIFO_DEPTH_LOG2:0]  fifo_count;
  logic [BUS_DATA_W-1:0]     word_q, word_d;
  logic [1:0]                idx_q, idx_d;
  logic                      valid_q, valid_d;
  logic                      start_go, req_fire, ack_take, accept, data_accept, word_last;
  logic                      stream_done;
  logic [7:0]                byte_sel;
`ifdef SD_DMA_TX_CRC16_EN
  logic [15:0]               crc_q, crc_d;
  tail_state_e               tail_q, tail_d;
`endif

  assign start_go    = i_start && !i_stop && (state_q == IDLE);
  assign req_fire    = o_request && !i_busy;
  assign ack_take    = (state_q == WAIT_ACK) && i_ack && !i_stop;
  assign accept      = valid_q && i_byte_ready;
`ifdef SD_DMA_TX_CRC16_EN
  assign data_accept = accept && (tail_q == TAIL_NONE);
`else
  assign data_accept = accept;
`endif
  assign word_last   = data_accept && (idx_q == 2'd3);
  assign stream_done = (state_q == DONE) && fifo_empty && !valid_q;
  assign fifo_push   = ack_take;

  sd_tx_word_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk_i       (i_clk),
    .rst_i       (i_reset),
    .push_i      (fifo_push),
    .push_data_i (i_data),
    .pop_i       (fifo_pop),
    .flush_i     (i_stop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (i_start) state_d = REQ;
        REQ:      if (req_fire) state_d = WAIT_ACK;
        WAIT_ACK: if (i_ack) state_d = (left_q == '0) ? DONE : REQ;
        DONE:     if (stream_done) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Requests are only issued from REQ, where no read is in flight, so a free slot suffices
  always_comb begin
    o_request = (state_q == REQ) && (fifo_count < DEPTH_CNT);
    o_busy    = (state_q != IDLE) && !stream_done;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_q <= '0;
      left_q <= '0;
    end else if (start_go) begin
      addr_q <= i_base & ~24'h000003;
      left_q <= i_length;
    end else if (ack_take) begin
      addr_q <= addr_q + 24'd4;
      left_q <= left_q - 1'b1;
    end
  end

  // Unpacker: a word is loaded whenever the byte slot is empty or its last byte leaves
  always_comb begin
    word_d   = word_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    fifo_pop = 1'b0;
`ifdef SD_DMA_TX_CRC16_EN
    crc_d    = crc_q;
    tail_d   = tail_q;
`endif
    if (data_accept) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == 2'd3) valid_d = 1'b0;
    end
    if (!i_stop && !fifo_empty && (!valid_q || word_last)) begin
      fifo_pop = 1'b1;
      word_d   = fifo_head;
      idx_d    = 2'd0;
      valid_d  = 1'b1;
    end
`ifdef SD_DMA_TX_CRC16_EN
    if (data_accept) crc_d = crc16_update(crc_q, byte_sel);
    if (start_go)    crc_d = 16'h0000;
    if (word_last && fifo_empty && (state_q == DONE)) begin
      tail_d  = TAIL_HI;
      valid_d = 1'b1;
    end
    if (accept && (tail_q == TAIL_HI)) tail_d = TAIL_LO;
    if (accept && (tail_q == TAIL_LO)) begin
      tail_d  = TAIL_NONE;
      valid_d = 1'b0;
    end
`endif
    if (i_stop) begin
      valid_d = 1'b0;
      idx_d   = 2'd0;
`ifdef SD_DMA_TX_CRC16_EN
      tail_d  = TAIL_NONE;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
`ifdef SD_DMA_TX_CRC16_EN
      crc_q   <= '0;
      tail_q  <= TAIL_NONE;
`endif
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
`ifdef SD_DMA_TX_CRC16_EN
      crc_q   <= crc_d;
      tail_q  <= tail_d;
`endif
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    byte_sel = word_q[31:24];
      2'd1:    byte_sel = word_q[23:16];
      2'd2:    byte_sel = word_q[15:8];
      default: byte_sel = word_q[7:0];
    endcase
`ifdef SD_DMA_TX_CRC16_EN
    if (tail_q == TAIL_HI) byte_sel = crc_q[15:8];
    if (tail_q == TAIL_LO) byte_sel = crc_q[7:0];
`endif
  end

  assign o_byte       = byte_sel;
  assign o_byte_valid = valid_q;
  assign o_address    = addr_q;
  assign o_write      = 1'b0;
  assign o_fifo_empty = fifo_empty;
  assign o_fifo_full  = fifo_full;
`ifdef SD_DMA_TX_CRC16_EN
  assign o_crc16      = crc_q;
`else
  assign o_crc16      = 16'h0000;
`endif

endmodule

// File: tb/tb_sd_dma_tx.sv
// Scoreboard bench for sd_dma_tx: expected bytes and request addresses are queued at
// stimulus time and popped by independent bus/stream monitors.
module tb_sd_dma_tx;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_stop, i_busy, i_ack, i_byte_ready;
  logic [23:0] i_base;
  logic [7:0]  i_length;
  logic [31:0] i_data;
  logic        o_busy, o_fifo_empty, o_fifo_full, o_request, o_write, o_byte_valid;
  logic [23:0] o_address;
  logic [7:0]  o_byte;
  logic [15:0] o_crc16;

  always #5 i_clk = ~i_clk;

  sd_dma_tx dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_base       (i_base),
    .i_length     (i_length),
    .o_busy       (o_busy),
    .o_fifo_empty (o_fifo_empty),
    .o_fifo_full  (o_fifo_full),
    .o_request    (o_request),
    .o_write      (o_write),
    .i_busy       (i_busy),
    .i_ack        (i_ack),
    .o_address    (o_address),
    .i_data       (i_data),
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .o_crc16      (o_crc16)
  );

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] mem [logic [23:0]];
  logic [31:0] wordTab [$];
  logic [7:0]  expByte [$];
  logic [23:0] expAddr [$];
  int          accepted = 0;
  int          target = 0;
  int          reqCount = 0;
  int          lat = 0;
  logic [23:0] pendAddr = '0;
  int          readyMode = 0;
  int          cyc = 0;
  bit          fullSeen = 0;
  int          reqWhileFull = 0;
  bit          stallPrev = 0;
  logic [7:0]  prevByte = '0;
  logic [15:0] expCrc = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] modelCrc(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic applyStimulus(input logic [23:0] base, input int len);
    logic [23:0] a;
    logic [7:0]  v;
    logic [15:0] c;
    c = 16'h0000;
    for (int i = 0; i <= len; i++) begin
      a = base + 24'(4 * i);
      mem[a] = wordTab[i];
      expAddr.push_back(a);
      for (int b = 3; b >= 0; b--) begin
        v = wordTab[i][8*b +: 8];
        expByte.push_back(v);
        c = modelCrc(c, v);
      end
    end
    expCrc = c;
`ifdef SD_DMA_TX_CRC16_EN
    expByte.push_back(c[15:8]);
    expByte.push_back(c[7:0]);
    target = accepted + 4 * (len + 1) + 2;
`else
    target = accepted + 4 * (len + 1);
`endif
    i_base   = base;
    i_length = 8'(len);
    @(posedge i_clk); #1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic waitComplete(input string name);
    int n;
    n = 0;
    while (accepted < target && n < 3000) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (accepted < target) begin
      checkOutput({name, " byte count (timeout)"}, 32'(accepted), 32'(target));
    end else begin
      checkOutput({name, " busy low after last byte"}, {31'b0, o_busy}, 32'd0);
      checkOutput({name, " scoreboard drained"}, 32'(expByte.size()), 32'd0);
`ifdef SD_DMA_TX_CRC16_EN
      checkOutput({name, " crc16"}, {16'b0, o_crc16}, {16'b0, expCrc});
`else
      checkOutput({name, " crc16 tied low"}, {16'b0, o_crc16}, 32'd0);
`endif
    end
  endtask

  // Stream monitor: pops an expected byte on each accepted transfer
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge i_clk);
      if (stallPrev) begin
        checkOutput("held valid under backpressure", {31'b0, o_byte_valid}, 32'd1);
        checkOutput("held byte under backpressure", {24'b0, o_byte}, {24'b0, prevByte});
      end
      if (o_byte_valid && i_byte_ready) begin
        accepted++;
        if (expByte.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected byte: got 0x%0h, expected no byte", o_byte);
        end else begin
          e = expByte.pop_front();
          checkOutput("stream byte", {24'b0, o_byte}, {24'b0, e});
        end
      end
      if (o_fifo_full) fullSeen = 1'b1;
      if (o_fifo_full && o_request) reqWhileFull++;
      stallPrev = o_byte_valid && !i_byte_ready && !i_stop && !i_reset;
      prevByte  = o_byte;
    end
  end

  // Bus model: fixed two-cycle read latency, checks each accepted request address
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge i_clk);
      i_ack = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          i_ack  = 1'b1;
          i_data = mem.exists(pendAddr) ? mem[pendAddr] : 32'hDEADBEEF;
        end
      end
      if (o_request && !i_busy) begin
        reqCount++;
        if (expAddr.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected request: got address 0x%0h, expected no request", o_address);
        end else begin
          e = expAddr.pop_front();
          checkOutput("request address", {8'b0, o_address}, {8'b0, e});
        end
        pendAddr = o_address;
        lat = 2;
      end
    end
  end

  initial begin
    forever begin
      @(posedge i_clk); #2;
      cyc++;
      case (readyMode)
        1:       i_byte_ready = (cyc % 3 == 0);
        2:       i_byte_ready = 1'b0;
        default: i_byte_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #2000000;
    testsFailed++;
    $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0, a0, n;
    i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_busy = 1'b0; i_ack = 1'b0;
    i_byte_ready = 1'b1; i_base = '0; i_length = '0; i_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset o_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("reset o_request", {31'b0, o_request}, 32'd0);
    checkOutput("reset o_write", {31'b0, o_write}, 32'd0);
    checkOutput("reset o_address", {8'b0, o_address}, 32'd0);
    checkOutput("reset o_byte", {24'b0, o_byte}, 32'd0);
    checkOutput("reset o_byte_valid", {31'b0, o_byte_valid}, 32'd0);
    checkOutput("reset o_crc16", {16'b0, o_crc16}, 32'd0);
    checkOutput("reset o_fifo_empty", {31'b0, o_fifo_empty}, 32'd1);
    checkOutput("reset o_fifo_full", {31'b0, o_fifo_full}, 32'd0);
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);

    // Single word
    r0 = reqCount;
    wordTab = '{32'hA1B2C3D4};
    applyStimulus(24'h000100, 0);
    waitComplete("single word");
    checkOutput("single word request count", 32'(reqCount - r0), 32'd1);
    repeat (3) @(posedge i_clk);

    // Consumer backpressure fills the FIFO
    fullSeen = 1'b0;
    reqWhileFull = 0;
    readyMode = 1;
    wordTab = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
                32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
    applyStimulus(24'h000200, 7);
    waitComplete("backpressure");
    checkOutput("backpressure fifo reached full", {31'b0, fullSeen}, 32'd1);
    checkOutput("backpressure no request while full", 32'(reqWhileFull), 32'd0);
    readyMode = 0;
    repeat (3) @(posedge i_clk);

    // Bus stall on the second request
    r0 = reqCount;
    wordTab = '{32'h10203040, 32'h50607080, 32'h90A0B0C0};
    applyStimulus(24'h000400, 2);
    n = 0;
    while (reqCount < r0 + 1 && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    checkOutput("stall first request seen", 32'(reqCount - r0), 32'd1);
    i_busy = 1'b1;
    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("stall o_request held", {31'b0, o_request}, 32'd1);
    checkOutput("stall o_address held", {8'b0, o_address}, 32'h000404);
    @(posedge i_clk); #1;
    i_busy = 1'b0;
    waitComplete("bus stall");
    repeat (3) @(posedge i_clk);

    // Abort with a read outstanding, then restart elsewhere
    a0 = accepted;
    wordTab = '{32'hAABBCCDD, 32'hEEFF0011, 32'h22334455, 32'h66778899,
                32'h13579BDF, 32'h2468ACE0, 32'h0F1E2D3C, 32'h4B5A6978};
    applyStimulus(24'h000800, 7);
    n = 0;
    while (accepted < a0 + 5 && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    readyMode = 2;
    checkOutput("abort five bytes streamed", 32'(accepted - a0), 32'd5);
    n = 0;
    while (lat == 0 && n < 200) begin
      @(posedge i_clk); #1;
      n++;
    end
    checkOutput("abort read outstanding", {31'b0, (lat > 0)}, 32'd1);
    i_stop = 1'b1;
    expByte.delete();
    expAddr.delete();
    target = accepted;
    @(posedge i_clk); #1;
    i_stop = 1'b0;
    checkOutput("abort byte_valid low", {31'b0, o_byte_valid}, 32'd0);
    checkOutput("abort fifo empty", {31'b0, o_fifo_empty}, 32'd1);
    checkOutput("abort busy low", {31'b0, o_busy}, 32'd0);
    checkOutput("abort request low", {31'b0, o_request}, 32'd0);
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("late ack ignored fifo empty", {31'b0, o_fifo_empty}, 32'd1);
    checkOutput("late ack ignored byte_valid", {31'b0, o_byte_valid}, 32'd0);
    readyMode = 0;
    wordTab = '{32'hC0FFEE01, 32'hBADC0DE5};
    applyStimulus(24'h000C00, 1);
    waitComplete("restart after abort");
    repeat (3) @(posedge i_clk);

    // Address wrap
    wordTab = '{32'h5A5AA5A5, 32'h3C3CC3C3};
    applyStimulus(24'hFFFFFC, 1);
    waitComplete("address wrap");
    repeat (3) @(posedge i_clk);

`ifdef SD_DMA_TX_CRC16_EN
    wordTab.delete();
    for (int i = 0; i < 128; i++) wordTab.push_back(32'hFFFFFFFF);
    applyStimulus(24'h000000, 127);
    waitComplete("crc block");
    checkOutput("crc block value", {16'b0, o_crc16}, 32'h00007FA1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
